// File: rtl/sd_txf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_txf_pkg
//  Purpose  : Shared constants and helpers for the SD TX FIFO filler.
//             Holds the state encoding, Wishbone constants and the
//             FIFO free-space calculation.
//  Revision : 1.0 - initial release
// ============================================================================
package sd_txf_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_SPACE = 3'd1;
    localparam logic [2:0] ST_FETCH      = 3'd2;
    localparam logic [2:0] ST_GAP        = 3'd3;
    localparam logic [2:0] ST_FINISH     = 3'd4;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Words the FIFO can still accept. A write strobe that is on the wire
    // this cycle has not reached the level count yet, so it is charged here.
    // Saturates at zero if the level ever exceeds the depth.
    function automatic logic [6:0] free_space(
        input logic [6:0] depth,
        input logic [5:0] level,
        input logic       wr_pending
    );
        logic [7:0] used;
        used = {2'b00, level} + {7'd0, wr_pending};
        if (used >= {1'b0, depth}) begin
            return 7'd0;
        end
        return depth - used[6:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_txf_wb_beat.sv
`default_nettype none
// ============================================================================
//  Module   : sd_txf_wb_beat
//  Purpose  : Single-beat Wishbone read handler. Holds cyc/stb until the
//             controlling FSM drops it (or a bus error ends it), qualifies
//             ack/err, and registers the read word towards the TX FIFO.
//  Config   : SD_TXF_BYTE_SWAP_EN - byte-reverse read data before the FIFO.
//  Ports    : clk, rst_n       clock, synchronous active-low reset
//             i_launch         raise cyc/stb at next edge
//             i_drop           lower cyc/stb at next edge (wins over launch)
//             i_flush          suppress the FIFO write of a beat this cycle
//             i_wb_dat/ack/err Wishbone read return path
//             o_cyc            cyc/stb value
//             o_beat_ok/err    qualified beat completion this cycle
//             o_fifo_wr/dat    registered FIFO write port
//  Revision : 1.0 - initial release
// ============================================================================
module sd_txf_wb_beat (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_launch,
    input  logic        i_drop,
    input  logic        i_flush,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_cyc,
    output logic        o_beat_ok,
    output logic        o_beat_err,
    output logic        o_fifo_wr,
    output logic [31:0] o_fifo_dat
);

    logic        r_cyc;
    logic        r_fifo_wr;
    logic [31:0] r_fifo_dat;
    logic [31:0] w_dat;

`ifdef SD_TXF_BYTE_SWAP_EN
    assign w_dat = {i_wb_dat[7:0], i_wb_dat[15:8], i_wb_dat[23:16], i_wb_dat[31:24]};
`else
    assign w_dat = i_wb_dat;
`endif

    // An error on the same beat as an ack takes precedence: data is discarded.
    assign o_beat_ok  = r_cyc & i_wb_ack & ~i_wb_err;
    assign o_beat_err = r_cyc & i_wb_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc      <= 1'b0;
            r_fifo_wr  <= 1'b0;
            r_fifo_dat <= 32'd0;
        end else begin
            if (i_drop || o_beat_err) begin
                r_cyc <= 1'b0;
            end else if (i_launch) begin
                r_cyc <= 1'b1;
            end
            r_fifo_wr <= o_beat_ok & ~i_flush;
            if (o_beat_ok && !i_flush) begin
                r_fifo_dat <= w_dat;
            end
        end
    end

    assign o_cyc      = r_cyc;
    assign o_fifo_wr  = r_fifo_wr;
    assign o_fifo_dat = r_fifo_dat;

endmodule
`default_nettype wire

// File: rtl/sd_tx_fifo_filler.sv
`default_nettype none
// ============================================================================
//  Module   : sd_tx_fifo_filler
//  Purpose  : Wishbone read master that prefetches xfer_words 32-bit words
//             into the SD TX FIFO in bursts of BURST_LEN single beats,
//             launching a burst only when the FIFO has room for all of it.
//  Config   : SD_TXF_BYTE_SWAP_EN - byte-reverse words written to the FIFO.
//  Ports    : clk/rst_n               clock, synchronous active-low reset
//             start/abort             control pulses (abort wins)
//             base_adr/xfer_words     transfer descriptor
//             busy/done/err           status
//             m_wb_*                  Wishbone read master
//             fifo_wr/fifo_dat        TX FIFO write port (registered)
//             fifo_full/fifo_level    TX FIFO status
//  Revision : 1.0 - initial release
// ============================================================================
module sd_tx_fifo_filler
    import sd_txf_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      base_adr,
    input  logic [CNT_W-1:0] xfer_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             m_wb_cyc_o,
    output logic             m_wb_stb_o,
    output logic             m_wb_we_o,
    output logic [3:0]       m_wb_sel_o,
    output logic [31:0]      m_wb_adr_o,
    input  logic [31:0]      m_wb_dat_i,
    input  logic             m_wb_ack_i,
    input  logic             m_wb_err_i,
    output logic             fifo_wr,
    output logic [31:0]      fifo_dat,
    input  logic             fifo_full,
    input  logic [5:0]       fifo_level
);

    localparam int               c_BEAT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] c_BURST     = CNT_W'(BURST_LEN);

    logic [2:0]          r_state;
    logic [31:0]         r_adr;
    logic [CNT_W-1:0]    r_rem;
    logic [c_BEAT_W-1:0] r_beat;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_cyc;
    logic                w_beat_ok;
    logic                w_beat_err;
    logic                w_fifo_wr;
    logic [6:0]          w_free;
    logic [CNT_W-1:0]    w_need;
    logic                w_space_ok;
    logic                w_active;
    logic                w_violation;
    logic                w_last_beat;
    logic                w_launch;
    logic                w_drop;

    assign w_free     = free_space(7'(FIFO_DEPTH), fifo_level, w_fifo_wr);
    // The final burst may be shorter than BURST_LEN; only wait for its size.
    assign w_need     = (r_rem < c_BURST) ? r_rem : c_BURST;
    assign w_space_ok = (CNT_W'(w_free) >= w_need);

    assign w_active    = (r_state == ST_WAIT_SPACE) || (r_state == ST_FETCH) ||
                         (r_state == ST_GAP);
    // A write landing on a full FIFO means the credit accounting broke.
    assign w_violation = w_fifo_wr & fifo_full & w_active;
    assign w_last_beat = (r_beat == c_LAST_BEAT) || (r_rem == CNT_W'(1));

    assign w_launch = !abort && !w_violation && (r_state == ST_WAIT_SPACE) && w_space_ok;
    assign w_drop   = abort || w_violation ||
                      ((r_state == ST_FETCH) && w_beat_ok && w_last_beat);

    sd_txf_wb_beat u_beat (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_launch   (w_launch),
        .i_drop     (w_drop),
        .i_flush    (w_violation),
        .i_wb_dat   (m_wb_dat_i),
        .i_wb_ack   (m_wb_ack_i),
        .i_wb_err   (m_wb_err_i),
        .o_cyc      (w_cyc),
        .o_beat_ok  (w_beat_ok),
        .o_beat_err (w_beat_err),
        .o_fifo_wr  (w_fifo_wr),
        .o_fifo_dat (fifo_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_adr   <= 32'd0;
            r_rem   <= '0;
            r_beat  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else if (w_violation) begin
                r_err   <= 1'b1;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_FINISH;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_err <= 1'b0;
                            if (xfer_words != '0) begin
                                r_adr   <= base_adr & 32'hFFFF_FFFC;
                                r_rem   <= xfer_words;
                                r_busy  <= 1'b1;
                                r_state <= ST_WAIT_SPACE;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_SPACE: begin
                        if (w_space_ok) begin
                            r_beat  <= '0;
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (w_beat_err) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FINISH;
                        end else if (w_beat_ok) begin
                            r_adr  <= r_adr + WORD_BYTES;
                            r_rem  <= r_rem - CNT_W'(1);
                            r_beat <= r_beat + c_BEAT_W'(1);
                            if (w_last_beat) begin
                                r_state <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (r_rem != '0) begin
                            r_state <= ST_WAIT_SPACE;
                        end else begin
                            // Last write is on the wire this cycle; done follows it.
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FINISH;
                        end
                    end
                    ST_FINISH: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign m_wb_cyc_o = w_cyc;
    assign m_wb_stb_o = w_cyc;
    assign m_wb_we_o  = 1'b0;
    assign m_wb_sel_o = WB_SEL_ALL;
    assign m_wb_adr_o = r_adr;
    assign fifo_wr    = w_fifo_wr;

endmodule
`default_nettype wire

// File: tb/tb_sd_tx_fifo_filler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_tx_fifo_filler
//  Purpose  : Directed self-checking bench for sd_tx_fifo_filler with a
//             combinational Wishbone memory responder and a FIFO status
//             driven directly by the scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_tx_fifo_filler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] base_adr = 32'd0;
    logic [15:0] xfer_words = 16'd0;
    logic        busy, done, err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack, werr;
    logic        fifo_wr;
    logic [31:0] fifo_dat;
    logic        fifo_full = 1'b0;
    logic [5:0]  fifo_level = 6'd0;

    int beat_no  = 0;
    int stall_at = -1;
    int err_at   = -1;
    bit dat_ovr  = 1'b0;

    int checks = 0;
    int errors = 0;

    int   wr_cnt = 0, done_cnt = 0, rise_cnt = 0;
    logic prev_cyc = 1'b0;
    logic [31:0] adr_q[$];
    logic [31:0] dat_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] exp_fifo(input logic [31:0] d);
`ifdef SD_TXF_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    assign ack   = cyc & stb & (beat_no != stall_at) & (beat_no != err_at);
    assign werr  = cyc & stb & (beat_no == err_at);
    assign dat_i = dat_ovr ? 32'h1122_3344 : mem_word(adr);

    sd_tx_fifo_filler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_adr   (base_adr),
        .xfer_words (xfer_words),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .m_wb_cyc_o (cyc),
        .m_wb_stb_o (stb),
        .m_wb_we_o  (we),
        .m_wb_sel_o (sel),
        .m_wb_adr_o (adr),
        .m_wb_dat_i (dat_i),
        .m_wb_ack_i (ack),
        .m_wb_err_i (werr),
        .fifo_wr    (fifo_wr),
        .fifo_dat   (fifo_dat),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level)
    );

    always @(posedge clk) begin
        if (cyc && stb && (ack || werr)) beat_no <= beat_no + 1;
    end

    always @(negedge clk) begin
        if (fifo_wr) begin
            wr_cnt <= wr_cnt + 1;
            dat_q.push_back(fifo_dat);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (cyc && !prev_cyc) rise_cnt <= rise_cnt + 1;
        prev_cyc <= cyc;
        if (cyc && ack) adr_q.push_back(adr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        base_adr   = b;
        xfer_words = n;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, done, err, cyc, stb, we, fifo_wr} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {busy, done, err, cyc, stb, we, fifo_wr});
        end
        checks++;
        if (adr !== 32'd0 || fifo_dat !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: adr %h dat %h expected 0", adr, fifo_dat);
        end
        checks++;
        if (sel !== 4'hF) begin
            errors++;
            $display("FAIL reset_sel: got %h expected f", sel);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_len();
        int r0;
        r0 = rise_cnt;
        pulse_start(32'h0000_0100, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done %b busy %b expected 1 0", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_pulse: done %b expected 0", done);
        end
        step();
        checks++;
        if (rise_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL zero_len_cyc: cyc rises %0d expected 0", rise_cnt - r0);
        end
    endtask

    task automatic test_basic();
        int w0, d0, r0, q0, a0;
        bit ok;
        w0 = wr_cnt; d0 = done_cnt; r0 = rise_cnt; q0 = dat_q.size(); a0 = adr_q.size();
        fifo_level = 6'd0;
        pulse_start(32'h0000_1000, 16'd8);
        checks++;
        if (busy !== 1'b1 || cyc !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy %b cyc %b expected 1 0", busy, cyc);
        end
        step();
        checks++;
        if (cyc !== 1'b1 || adr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL basic_first_cyc: cyc %b adr %h expected 1 00001000", cyc, adr);
        end
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: done %b expected 1", done);
        end
        step();
        checks++;
        if (wr_cnt - w0 !== 8 || rise_cnt - r0 !== 2 || done_cnt - d0 !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts: wr %0d tenures %0d done %0d err %b expected 8 2 1 0",
                     wr_cnt - w0, rise_cnt - r0, done_cnt - d0, err);
        end
        if (dat_q.size() >= q0 + 8 && adr_q.size() >= a0 + 8) begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] ea;
                ea = 32'h0000_1000 + 32'(4 * i);
                checks++;
                if (adr_q[a0 + i] !== ea || dat_q[q0 + i] !== exp_fifo(mem_word(ea))) begin
                    errors++;
                    $display("FAIL basic_word%0d: adr %h dat %h expected %h %h",
                             i, adr_q[a0 + i], dat_q[q0 + i], ea, exp_fifo(mem_word(ea)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int w0, r0;
        bit ok;
        w0 = wr_cnt; r0 = rise_cnt;
        fifo_level = 6'd6;
        pulse_start(32'h0000_2000, 16'd6);
        repeat (10) step();
        checks++;
        if (rise_cnt - r0 !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: tenures %0d busy %b expected 0 1", rise_cnt - r0, busy);
        end
        fifo_level = 6'd4;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cyc) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_launch: cyc %b expected 1", cyc);
        end
        fifo_level = 6'd7;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!cyc) break;
        end
        repeat (8) step();
        checks++;
        if (rise_cnt - r0 !== 1 || wr_cnt - w0 !== 4) begin
            errors++;
            $display("FAIL bp_first_burst: tenures %0d wr %0d expected 1 4", rise_cnt - r0, wr_cnt - w0);
        end
        fifo_level = 6'd6;
        wait_done(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: done %b expected 1", done);
        end
        step();
        checks++;
        if (rise_cnt - r0 !== 2 || wr_cnt - w0 !== 6) begin
            errors++;
            $display("FAIL bp_total: tenures %0d wr %0d expected 2 6", rise_cnt - r0, wr_cnt - w0);
        end
        fifo_level = 6'd0;
    endtask

    task automatic test_byte_swap();
        bit ok;
        logic [31:0] expv;
`ifdef SD_TXF_BYTE_SWAP_EN
        expv = 32'h4433_2211;
`else
        expv = 32'h1122_3344;
`endif
        dat_ovr = 1'b1;
        pulse_start(32'h0000_3000, 16'd1);
        wait_done(30, ok);
        step();
        dat_ovr = 1'b0;
        checks++;
        if (!ok || dat_q.size() == 0 || dat_q[dat_q.size() - 1] !== expv) begin
            errors++;
            $display("FAIL byte_swap: ok %b dat %h expected %h", ok,
                     (dat_q.size() == 0) ? 32'd0 : dat_q[dat_q.size() - 1], expv);
        end
    endtask

    task automatic test_bus_err();
        int w0;
        bit ok;
        w0 = wr_cnt;
        err_at = beat_no + 2;
        pulse_start(32'h0000_4000, 16'd5);
        wait_done(40, ok);
        checks++;
        if (!ok || err !== 1'b1 || busy !== 1'b0 || cyc !== 1'b0) begin
            errors++;
            $display("FAIL bus_err_state: ok %b err %b busy %b cyc %b expected 1 1 0 0", ok, err, busy, cyc);
        end
        step();
        checks++;
        if (done !== 1'b0 || wr_cnt - w0 !== 2) begin
            errors++;
            $display("FAIL bus_err_writes: done %b wr %0d expected 0 2", done, wr_cnt - w0);
        end
        err_at = -1;
        w0 = wr_cnt;
        pulse_start(32'h0000_5000, 16'd1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bus_err_clear: err %b busy %b expected 0 1", err, busy);
        end
        wait_done(30, ok);
        step();
        checks++;
        if (!ok || wr_cnt - w0 !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL bus_err_recover: ok %b wr %0d err %b expected 1 1 0", ok, wr_cnt - w0, err);
        end
    endtask

    task automatic test_abort();
        int w0, d0, r0, b0;
        bit ok;
        w0 = wr_cnt; d0 = done_cnt; r0 = rise_cnt; b0 = beat_no;
        stall_at = b0 + 1;
        pulse_start(32'h0000_6000, 16'd16);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (beat_no == b0 + 1 && cyc) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_reach_beat2: beats %0d expected 1", beat_no - b0);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (cyc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: cyc %b busy %b expected 0 0", cyc, busy);
        end
        repeat (10) step();
        checks++;
        if (done_cnt - d0 !== 0 || wr_cnt - w0 !== 1 || rise_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL abort_quiet: done %0d wr %0d tenures %0d expected 0 1 1",
                     done_cnt - d0, wr_cnt - w0, rise_cnt - r0);
        end
        stall_at = -1;
        w0 = wr_cnt;
        pulse_start(32'h0000_7000, 16'd1);
        wait_done(30, ok);
        step();
        checks++;
        if (!ok || wr_cnt - w0 !== 1 || dat_q[dat_q.size() - 1] !== exp_fifo(mem_word(32'h0000_7000))) begin
            errors++;
            $display("FAIL abort_restart: ok %b wr %0d dat %h expected 1 1 %h", ok, wr_cnt - w0,
                     dat_q[dat_q.size() - 1], exp_fifo(mem_word(32'h0000_7000)));
        end
    endtask

    task automatic test_credit_violation();
        int w0;
        bit ok;
        w0 = wr_cnt;
        fifo_full = 1'b1;
        pulse_start(32'h0000_8000, 16'd4);
        wait_done(30, ok);
        checks++;
        if (!ok || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL credit_err: ok %b err %b busy %b expected 1 1 0", ok, err, busy);
        end
        step();
        checks++;
        if (wr_cnt - w0 !== 1 || cyc !== 1'b0) begin
            errors++;
            $display("FAIL credit_stop: wr %0d cyc %b expected 1 0", wr_cnt - w0, cyc);
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_basic();
        test_backpressure();
        test_byte_swap();
        test_bus_err();
        test_abort();
        test_credit_violation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
